// File: rtl/dds_wave_meter.sv
// dds_wave_meter
//   Measures the period and high time of a sampled DDS waveform. The sample
//   stream is registered once, then squared up by a hysteresis comparator.
//   Rising edges of the squared signal delimit the measured periods.
//
// Parameters
//   DATA_WIDTH     - width of wave_in / thresholds
//   CNT_WIDTH      - width of the period and high-time counters
//   TIMEOUT_CYCLES - max clocks between accepted rising edges (< 2^CNT_WIDTH)
//
// Ports
//   clock      - single clock
//   reset      - asynchronous active-low reset
//   wave_in    - unsigned waveform sample
//   thr_hi     - comparator set threshold
//   thr_lo     - comparator clear threshold
//   start      - one-cycle measurement request (also aborts a running one)
//   continuous - 1 = keep measuring after each result, 0 = single shot
//   busy       - high while armed or measuring
//   valid      - one-cycle pulse when period/high_time update
//   timeout    - sticky, set when no rising edge arrives in time
//   period     - clocks between consecutive rising edges
//   high_time  - clocks with the comparator high within that period
//   sq_out     - comparator state
module dds_wave_meter #(
  parameter int DATA_WIDTH     = 12,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wave_in,
  input  logic [DATA_WIDTH-1:0] thr_hi,
  input  logic [DATA_WIDTH-1:0] thr_lo,
  input  logic                  start,
  input  logic                  continuous,
  output logic                  busy,
  output logic                  valid,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  period,
  output logic [CNT_WIDTH-1:0]  high_time,
  output logic                  sq_out
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  // The counter value after which one more clock without a rise means the
  // limit has been reached.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] wave_q_reg;
  logic                  sq_reg;
  logic                  sq_next;
  logic                  sq_d_reg;
  logic                  rise;
  logic [CNT_WIDTH-1:0]  per_cnt_reg;
  logic [CNT_WIDTH-1:0]  high_cnt_reg;
  logic                  busy_reg;
  logic                  valid_reg;
  logic                  timeout_reg;
  logic [CNT_WIDTH-1:0]  period_reg;
  logic [CNT_WIDTH-1:0]  high_time_reg;

  // Comparator. With an inverted or collapsed window there is no hysteresis
  // band, so the output simply follows the upper threshold.
  always_comb begin
    sq_next = sq_reg;
    if (thr_lo >= thr_hi) begin
      sq_next = (wave_q_reg >= thr_hi);
    end else if (wave_q_reg >= thr_hi) begin
      sq_next = 1'b1;
    end else if (wave_q_reg <= thr_lo) begin
      sq_next = 1'b0;
    end
  end

  assign rise = sq_reg & ~sq_d_reg;

  // Sample register, comparator state and its one-clock delay.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wave_q_reg <= '0;
      sq_reg     <= 1'b0;
      sq_d_reg   <= 1'b0;
    end else begin
      wave_q_reg <= wave_in;
      sq_reg     <= sq_next;
      sq_d_reg   <= sq_reg;
    end
  end

  // Measurement FSM. Priority inside ARM/MEAS: start (abort and re-arm),
  // then rise (period boundary), then timeout, then plain counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      per_cnt_reg   <= '0;
      high_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      period_reg    <= '0;
      high_time_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= ARM;
            busy_reg     <= 1'b1;
            timeout_reg  <= 1'b0;
            per_cnt_reg  <= '0;
            high_cnt_reg <= '0;
          end
        end
        ARM, MEAS: begin
          if (start) begin
            state_reg    <= ARM;
            busy_reg     <= 1'b1;
            timeout_reg  <= 1'b0;
            per_cnt_reg  <= '0;
            high_cnt_reg <= '0;
          end else if (rise) begin
            // The rise cycle itself is the first clock of the new period,
            // and sq is high in it, so both counters restart at one.
            per_cnt_reg  <= CNT_ONE;
            high_cnt_reg <= CNT_ONE;
            if (state_reg == MEAS) begin
              period_reg    <= per_cnt_reg;
              high_time_reg <= high_cnt_reg;
              valid_reg     <= 1'b1;
              if (!continuous) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              state_reg <= MEAS;
            end
          end else if (per_cnt_reg == CNT_LAST) begin
            // Counting this clock would reach the limit: give up, keep the
            // last good result on the outputs.
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
          end else begin
            per_cnt_reg <= per_cnt_reg + CNT_ONE;
            if ((state_reg == MEAS) && sq_reg) begin
              high_cnt_reg <= high_cnt_reg + CNT_ONE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign valid     = valid_reg;
  assign timeout   = timeout_reg;
  assign period    = period_reg;
  assign high_time = high_time_reg;
  assign sq_out    = sq_reg;

endmodule

// File: tb/tb_dds_wave_meter.sv
module tb_dds_wave_meter;

  localparam int DW = 12;
  localparam int CW = 32;

  logic          clock;
  logic          reset;
  logic [DW-1:0] wave_in;
  logic [DW-1:0] thr_hi;
  logic [DW-1:0] thr_lo;
  logic          start;
  logic          continuous;
  logic          busy;
  logic          valid;
  logic          timeout;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          sq_out;

  dds_wave_meter #(
    .DATA_WIDTH    (DW),
    .CNT_WIDTH     (CW),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wave_in   (wave_in),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .start     (start),
    .continuous(continuous),
    .busy      (busy),
    .valid     (valid),
    .timeout   (timeout),
    .period    (period),
    .high_time (high_time),
    .sq_out    (sq_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int last_rise_cyc = 0;
  int phase = 0;
  bit sq_gen = 1'b0;
  logic [CW-1:0] last_per = '0;
  logic [CW-1:0] last_high = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then the
  // square-wave generator (40 clocks, 10 high) advances if enabled.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc_n++;
    if (valid === 1'b1) begin
      valid_cnt++;
      last_per       = period;
      last_high      = high_time;
      last_valid_cyc = cyc_n;
      $display("[TB] valid cyc=%0d period=%0d high_time=%0d", cyc_n, period, high_time);
    end
    if (sq_gen) begin
      wave_in = (phase < 10) ? 12'd4095 : 12'd0;
      if (phase == 0) last_rise_cyc = cyc_n;
      phase = (phase == 39) ? 0 : phase + 1;
    end
  endtask

  task automatic wait_valid(input int target, input int bound, output bit ok);
    int n;
    n = 0;
    while (valid_cnt < target && n < bound) begin
      tick();
      n++;
    end
    ok = (valid_cnt >= target);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bit ok;
    int base;
    int s_cyc;
    int n;
    int prev_cyc;
    int samp [6];
    bit sq_exp [6];

    samp   = '{2900, 3100, 2000, 3100, 900, 3100};
    sq_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b0; wave_in = '0; thr_hi = 12'd2048; thr_lo = 12'd2047;
    start = 1'b0; continuous = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_sq", sq_out, 0);
    reset = 1'b1;
    phase = 0; sq_gen = 1'b1;
    tick(); tick(); tick(); tick(); tick();

    // Single shot 40/10
    $display("[TB] single shot");
    pulse_start();
    chk("ss_busy_armed", busy, 1);
    base = valid_cnt;
    wait_valid(base + 1, 200, ok);
    chk("ss_got_valid", ok, 1);
    chk("ss_period", last_per, 40);
    chk("ss_high", last_high, 10);
    chk("ss_latency", last_valid_cyc - last_rise_cyc, 3);
    chk("ss_busy_done", busy, 0);
    for (int i = 0; i < 100; i++) tick();
    chk("ss_one_valid", valid_cnt - base, 1);

    // Continuous, five periods, then stop mid-period
    $display("[TB] continuous");
    continuous = 1'b1;
    pulse_start();
    base = valid_cnt;
    prev_cyc = 0;
    for (int k = 1; k <= 5; k++) begin
      wait_valid(base + k, 200, ok);
      chk("ct_got_valid", ok, 1);
      chk("ct_period", last_per, 40);
      chk("ct_high", last_high, 10);
      if (k > 1) chk("ct_spacing", last_valid_cyc - prev_cyc, 40);
      prev_cyc = last_valid_cyc;
      chk("ct_busy", busy, 1);
    end
    tick(); tick(); tick(); tick(); tick();
    continuous = 1'b0;
    wait_valid(base + 6, 200, ok);
    chk("ct_last_valid", ok, 1);
    chk("ct_last_spacing", last_valid_cyc - prev_cyc, 40);
    chk("ct_stop_busy", busy, 0);

    // Hysteresis: 3000/1000 window
    $display("[TB] hysteresis");
    sq_gen = 1'b0; wave_in = '0;
    thr_hi = 12'd3000; thr_lo = 12'd1000;
    tick(); tick(); tick(); tick();
    chk("hy_sq_init", sq_out, 0);
    pulse_start();
    base = valid_cnt;
    for (int i = 0; i < 7; i++) begin
      wave_in = DW'(samp[(i < 6) ? i : 5]);
      tick();
      if (i >= 1) chk("hy_sq", sq_out, sq_exp[i-1]);
    end
    wait_valid(base + 1, 10, ok);
    chk("hy_got_valid", ok, 1);
    chk("hy_period", last_per, 4);
    chk("hy_high", last_high, 3);
    chk("hy_busy", busy, 0);

    // Inverted window: plain compare against thr_hi
    $display("[TB] inverted window");
    thr_hi = 12'd1000; thr_lo = 12'd2000;
    wave_in = '0; tick(); tick(); tick();
    chk("inv_sq_low", sq_out, 0);
    wave_in = 12'd1500; tick(); tick();
    chk("inv_sq_set", sq_out, 1);
    wave_in = 12'd999; tick(); tick();
    chk("inv_sq_clr", sq_out, 0);

    // Timeout with a flat input
    $display("[TB] timeout");
    wave_in = '0;
    thr_hi = 12'd2048; thr_lo = 12'd2047;
    tick(); tick(); tick();
    base = valid_cnt;
    pulse_start();
    n = 0;
    while (timeout !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 1000);
    chk("to_flag", timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_period_kept", period, 4);
    chk("to_high_kept", high_time, 3);
    chk("to_no_valid", valid_cnt - base, 0);
    pulse_start();
    chk("to_cleared", timeout, 0);
    chk("to_rearmed", busy, 1);

    // Reset in the middle of a measurement
    $display("[TB] reset mid-measurement");
    continuous = 1'b1;
    phase = 0; sq_gen = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    chk("mr_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", valid, 0);
    chk("mr_timeout", timeout, 0);
    chk("mr_period", period, 0);
    chk("mr_high", high_time, 0);
    chk("mr_sq", sq_out, 0);
    base = valid_cnt;
    tick(); tick(); tick();
    reset = 1'b1;
    continuous = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mr_no_valid", valid_cnt - base, 0);
    chk("mr_idle", busy, 0);
    chk("mr_period_after", period, 0);

    // Start coinciding with a rise while armed
    $display("[TB] start on rise");
    n = 0;
    while ((cyc_n - last_rise_cyc) != 5 && n < 100) begin
      tick();
      n++;
    end
    pulse_start();
    n = 0;
    while ((cyc_n - last_rise_cyc) != 2 && n < 100) begin
      tick();
      n++;
    end
    chk("sr_aligned", cyc_n - last_rise_cyc, 2);
    start = 1'b1;
    tick();
    s_cyc = cyc_n;
    start = 1'b0;
    base = valid_cnt;
    wait_valid(base + 1, 200, ok);
    chk("sr_got_valid", ok, 1);
    chk("sr_delay", last_valid_cyc - s_cyc, 80);
    chk("sr_period", last_per, 40);
    chk("sr_high", last_high, 10);
    chk("sr_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_wave_meter.md
DDS_WAVE_METER -- requirements
Module: dds_wave_meter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, width of sampled waveform input.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of period and high-time counters.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576, maximum clocks allowed between accepted rising edges; SHALL be below 2^CNT_WIDTH.
REQ-004 SHALL have port clock, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port wave_in, input, DATA_WIDTH, unsigned waveform sample (DDS sin/tri/saw/sqr output).
REQ-007 SHALL have port thr_hi, input, DATA_WIDTH, upper comparator threshold.
REQ-008 SHALL have port thr_lo, input, DATA_WIDTH, lower comparator threshold.
REQ-009 SHALL have port start, input, 1, single-cycle measurement request.
REQ-010 SHALL have port continuous, input, 1, 1 = re-arm after each result; 0 = single shot.
REQ-011 SHALL have port busy, output, 1, high in ARM or MEAS.
REQ-012 SHALL have port valid, output, 1, one-cycle pulse when period/high_time update.
REQ-013 SHALL have port timeout, output, 1, sticky flag, set on timeout, cleared by start.
REQ-014 SHALL have port period, output, CNT_WIDTH, clocks between consecutive rising edges.
REQ-015 SHALL have port high_time, output, CNT_WIDTH, clocks with sq=1 within that period.
REQ-016 SHALL have port sq_out, output, 1, comparator state.

Function
REQ-017 Stage 1: wave_q SHALL register wave_in every clock.
REQ-018 Stage 2 comparator, unsigned compare on wave_q: sq 0->1 when wave_q >= thr_hi; sq 1->0 when wave_q <= thr_lo; else hold.
REQ-019 If thr_lo >= thr_hi, sq SHALL equal (wave_q >= thr_hi), no hysteresis.
REQ-020 rise SHALL be sq & ~sq_d, with sq_d = sq delayed one clock.
REQ-021 FSM states SHALL be IDLE, ARM, MEAS.
REQ-022 IDLE: on start -> ARM; clear timeout; per_cnt, high_cnt <= 0.
REQ-023 ARM: on rise -> MEAS with per_cnt <= 1, high_cnt <= 1; otherwise per_cnt increments.
REQ-024 MEAS, no rise: per_cnt +1; high_cnt +1 when sq=1.
REQ-025 MEAS, rise: period <= per_cnt, high_time <= high_cnt, valid <= 1 next clock; counters <= 1; stay MEAS if continuous=1, else IDLE.
REQ-026 Timeout: in ARM or MEAS, per_cnt reaching TIMEOUT_CYCLES without rise SHALL set timeout, go IDLE, leave period/high_time unchanged, no valid.
REQ-027 start in ARM or MEAS SHALL abort, clear counters and timeout, re-enter ARM; no valid for the aborted period.
REQ-028 start and rise in same cycle: start wins; the rise SHALL NOT arm MEAS.
REQ-029 Latency: valid and new period SHALL appear 3 clocks after the wave_in sample that completes the period crosses thr_hi.
REQ-030 continuous sampled only at result time; deasserting it mid-period SHALL stop after that result.
REQ-031 Counters SHALL never wrap (bounded by REQ-026).

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, wave_q=0, sq=sq_d=0, per_cnt=high_cnt=0.
REQ-033 Reset values: busy=0, valid=0, timeout=0, period=0, high_time=0, sq_out=0.
REQ-034 reset mid-MEAS SHALL discard the partial measurement with no valid pulse; release requires a new start.

Verification
REQ-035 thr_hi=2048, thr_lo=2047, continuous=0, wave_in square 4095/0, period 40, high 10, start -> one valid, period=40, high_time=10, then busy=0.
REQ-036 Same stimulus, continuous=1, 5 periods -> valid every 40 clocks, all results 40/10, busy stays 1.
REQ-037 wave_in=0 constant, TIMEOUT_CYCLES=1000, start -> timeout=1 and busy=0 after 1000 clocks; period unchanged; next start clears timeout.
REQ-038 thr_hi=3000, thr_lo=1000, samples 2900,3100,2000,3100,900,3100 -> sq_out sequence 0,1,1,1,0,1 (2-clock lag); one extra rise only at final 3100.
REQ-039 reset=0 during MEAS, then release -> all outputs 0, no valid, FSM IDLE.
REQ-040 start asserted in the same cycle as a rise, continuous=0 -> rise ignored; first valid reports the following full period of 40.
